// File: rtl/ysyx_220066_dmem_bridge.sv
// Data-side memory bridge: turns one outstanding core load/store into an
// AXI4-Lite-style read or write and returns a one-cycle completion pulse.
module ysyx_220066_dmem_bridge #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                MemRd,
  input  logic                MemWr,
  input  logic [63:0]         addr,
  input  logic [2:0]          wr_len,
  input  logic [DATA_W/8-1:0] wr_mask,
  input  logic [DATA_W-1:0]   data_Wr,
  output logic [DATA_W-1:0]   data_Rd,
  output logic                data_valid,
  output logic                data_error,
  output logic                ar_valid,
  input  logic                ar_ready,
  output logic [ADDR_W-1:0]   ar_addr,
  output logic [2:0]          ar_size,
  input  logic                r_valid,
  output logic                r_ready,
  input  logic [DATA_W-1:0]   r_data,
  input  logic [1:0]          r_resp,
  output logic                aw_valid,
  input  logic                aw_ready,
  output logic [ADDR_W-1:0]   aw_addr,
  output logic [2:0]          aw_size,
  output logic                w_valid,
  input  logic                w_ready,
  output logic [DATA_W-1:0]   w_data,
  output logic [DATA_W/8-1:0] w_strb,
  input  logic                b_valid,
  output logic                b_ready,
  input  logic [1:0]          b_resp
);

  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WREQ, WRESP, DONE} state_e;

  state_e              state, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [2:0]          size_q, size_d;
  logic [STRB_W-1:0]   strb_d;
  logic [DATA_W-1:0]   wdata_d, rdata_d;
  logic                data_valid_d, data_error_d;
  logic                ar_valid_d, r_ready_d, aw_valid_d, w_valid_d, b_ready_d;
  logic                aw_done, aw_done_d, w_done, w_done_d;
  logic                misalign;
  logic                aw_fire, w_fire;
  logic                unused_addr_hi;

  assign unused_addr_hi = ^addr[63:ADDR_W];

  assign ar_addr = addr_q;
  assign aw_addr = addr_q;
  assign ar_size = size_q;
  assign aw_size = size_q;

  assign aw_fire = aw_valid && aw_ready;
  assign w_fire  = w_valid && w_ready;

  // Natural alignment check; sizes beyond 8 bytes are rejected outright.
  always_comb begin
    misalign = 1'b1;
    case (wr_len)
      3'd0:    misalign = 1'b0;
      3'd1:    misalign = addr[0];
      3'd2:    misalign = |addr[1:0];
      3'd3:    misalign = |addr[2:0];
      default: misalign = 1'b1;
    endcase
  end

  always_comb begin
    state_d      = state;
    addr_d       = addr_q;
    size_d       = size_q;
    strb_d       = w_strb;
    wdata_d      = w_data;
    rdata_d      = data_Rd;
    data_valid_d = 1'b0;
    data_error_d = 1'b0;
    ar_valid_d   = ar_valid;
    r_ready_d    = r_ready;
    aw_valid_d   = aw_valid;
    w_valid_d    = w_valid;
    b_ready_d    = b_ready;
    aw_done_d    = aw_done;
    w_done_d     = w_done;
    case (state)
      IDLE: begin
        if (MemRd || MemWr) begin
          addr_d  = addr[ADDR_W-1:0];
          size_d  = wr_len;
          strb_d  = wr_mask;
          wdata_d = data_Wr;
          if ((MemRd && MemWr) || misalign) begin
            state_d      = DONE;
            rdata_d      = '0;
            data_valid_d = 1'b1;
            data_error_d = 1'b1;
          end else if (MemRd) begin
            state_d = RADDR;
          end else begin
            state_d    = WREQ;
            rdata_d    = '0;
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
            aw_done_d  = 1'b0;
            w_done_d   = 1'b0;
          end
        end
      end
      // AR is raised one cycle after entry and dropped after its handshake.
      RADDR: begin
        if (ar_valid && ar_ready) begin
          ar_valid_d = 1'b0;
          r_ready_d  = 1'b1;
          state_d    = RDATA;
        end else begin
          ar_valid_d = 1'b1;
        end
      end
      RDATA: begin
        if (r_valid && r_ready) begin
          rdata_d      = r_data;
          r_ready_d    = 1'b0;
          state_d      = DONE;
          data_valid_d = 1'b1;
          data_error_d = |r_resp;
        end
      end
      // AW and W complete independently, in any order.
      WREQ: begin
        aw_done_d = aw_done || aw_fire;
        w_done_d  = w_done || w_fire;
        if (aw_fire) aw_valid_d = 1'b0;
        if (w_fire)  w_valid_d  = 1'b0;
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          b_ready_d = 1'b1;
          state_d   = WRESP;
        end
      end
      WRESP: begin
        if (b_valid && b_ready) begin
          b_ready_d    = 1'b0;
          state_d      = DONE;
          data_valid_d = 1'b1;
          data_error_d = |b_resp;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      size_q     <= '0;
      w_strb     <= '0;
      w_data     <= '0;
      data_Rd    <= '0;
      data_valid <= 1'b0;
      data_error <= 1'b0;
      ar_valid   <= 1'b0;
      r_ready    <= 1'b0;
      aw_valid   <= 1'b0;
      w_valid    <= 1'b0;
      b_ready    <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
    end else begin
      state      <= state_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      w_strb     <= strb_d;
      w_data     <= wdata_d;
      data_Rd    <= rdata_d;
      data_valid <= data_valid_d;
      data_error <= data_error_d;
      ar_valid   <= ar_valid_d;
      r_ready    <= r_ready_d;
      aw_valid   <= aw_valid_d;
      w_valid    <= w_valid_d;
      b_ready    <= b_ready_d;
      aw_done    <= aw_done_d;
      w_done     <= w_done_d;
    end
  end

endmodule

// File: tb/tb_ysyx_220066_dmem_bridge.sv
// Directed bench for the dmem bridge: configurable-latency AXI-Lite slave,
// transaction-level expectation model and a per-cycle compare process.
module tb_ysyx_220066_dmem_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MemRd = 1'b0, MemWr = 1'b0;
  logic [63:0] addr = '0;
  logic [2:0]  wr_len = '0;
  logic [7:0]  wr_mask = '0;
  logic [63:0] data_Wr = '0;
  logic [63:0] data_Rd;
  logic        data_valid, data_error;
  logic        ar_valid, ar_ready = 1'b0;
  logic [31:0] ar_addr, aw_addr;
  logic [2:0]  ar_size, aw_size;
  logic        r_valid = 1'b0, r_ready;
  logic [63:0] r_data = '0;
  logic [1:0]  r_resp = '0;
  logic        aw_valid, aw_ready = 1'b0;
  logic        w_valid, w_ready = 1'b0;
  logic [63:0] w_data;
  logic [7:0]  w_strb;
  logic        b_valid = 1'b0, b_ready;
  logic [1:0]  b_resp = '0;

  ysyx_220066_dmem_bridge dut (
    .clk(clk), .rst(rst), .MemRd(MemRd), .MemWr(MemWr), .addr(addr),
    .wr_len(wr_len), .wr_mask(wr_mask), .data_Wr(data_Wr), .data_Rd(data_Rd),
    .data_valid(data_valid), .data_error(data_error),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_size(ar_size),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_size(aw_size),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb),
    .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Slave configuration
  int          cfg_ar_wait = 0, cfg_r_wait = 0, cfg_aw_wait = 0, cfg_w_wait = 0, cfg_b_wait = 0;
  logic [63:0] cfg_rdata = '0;
  logic [1:0]  cfg_rresp = '0, cfg_bresp = '0;

  // Handshake flags sampled by the monitor, consumed by the slave
  logic ar_hs = 0, r_hs = 0, aw_hs = 0, w_hs = 0, b_hs = 0;

  // Expectations from the model
  logic        active = 0, done = 0, exp_pre = 0, exp_err = 0, exp_is_rd = 0;
  int          exp_cyc = 0, dv_cyc = 0;
  logic [63:0] exp_rd = '0, exp_wdata = '0, last_rd = '0;
  logic [31:0] exp_addr = '0;
  logic [2:0]  exp_size = '0;
  logic [7:0]  exp_strb = '0;
  int          n_ar = 0, n_r = 0, n_aw = 0, n_w = 0, n_b = 0;
  logic        bus_seen = 0;

  // Slave: reacts shortly after each rising edge to the registered DUT outputs
  int   ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  logic r_pend = 0, b_pend = 0, got_aw = 0, got_w = 0;
  always @(posedge clk) begin
    #2;
    if (rst) begin
      ar_ready = 0; r_valid = 0; aw_ready = 0; w_ready = 0; b_valid = 0;
      r_pend = 0; b_pend = 0; got_aw = 0; got_w = 0;
      ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
    end else begin
      if (r_hs) r_pend = 0;
      if (ar_hs) begin r_pend = 1; r_cnt = cfg_r_wait; end
      ar_ready = ar_valid && (ar_cnt >= cfg_ar_wait);
      ar_cnt   = ar_valid ? ar_cnt + 1 : 0;
      r_valid  = r_pend && (r_cnt == 0);
      if (r_pend && r_cnt > 0) r_cnt--;
      r_data = r_valid ? cfg_rdata : 64'h0;
      r_resp = r_valid ? cfg_rresp : 2'b00;
      aw_ready = aw_valid && (aw_cnt >= cfg_aw_wait);
      aw_cnt   = aw_valid ? aw_cnt + 1 : 0;
      w_ready  = w_valid && (w_cnt >= cfg_w_wait);
      w_cnt    = w_valid ? w_cnt + 1 : 0;
      if (aw_hs) got_aw = 1;
      if (w_hs) got_w = 1;
      if (b_hs) b_pend = 0;
      if (got_aw && got_w) begin got_aw = 0; got_w = 0; b_pend = 1; b_cnt = cfg_b_wait; end
      b_valid = b_pend && (b_cnt == 0);
      if (b_pend && b_cnt > 0) b_cnt--;
      b_resp = b_valid ? cfg_bresp : 2'b00;
    end
  end

  // Compare process: checks DUT outputs against the model every cycle
  always @(negedge clk) begin
    ar_hs = ar_valid && ar_ready;
    r_hs  = r_valid && r_ready;
    aw_hs = aw_valid && aw_ready;
    w_hs  = w_valid && w_ready;
    b_hs  = b_valid && b_ready;
    if (!rst) begin
      if (active) begin
        if (ar_valid || aw_valid || w_valid || r_ready || b_ready) bus_seen = 1;
        if (ar_hs) begin
          n_ar++;
          chk("ar_addr", 64'(ar_addr), 64'(exp_addr));
          chk("ar_size", 64'(ar_size), 64'(exp_size));
        end
        if (r_hs) n_r++;
        if (aw_hs) begin
          n_aw++;
          chk("aw_addr", 64'(aw_addr), 64'(exp_addr));
          chk("aw_size", 64'(aw_size), 64'(exp_size));
        end
        if (w_hs) begin
          n_w++;
          chk("w_data", w_data, exp_wdata);
          chk("w_strb", 64'(w_strb), 64'(exp_strb));
        end
        if (b_hs) n_b++;
        chk("dv_timing", 64'(data_valid), 64'(cyc == exp_cyc));
        if (data_valid) begin
          chk("data_error", 64'(data_error), 64'(exp_err));
          chk("data_Rd", data_Rd, exp_rd);
          dv_cyc  = cyc;
          last_rd = data_Rd;
          active  = 0;
          done    = 1;
        end
      end else begin
        chk("dv_idle", 64'(data_valid), 64'h0);
      end
    end
  end

  task automatic slave_cfg(input int arw, input int rw, input int aww, input int ww, input int bw,
                           input logic [63:0] rd, input logic [1:0] rr, input logic [1:0] br);
    cfg_ar_wait = arw; cfg_r_wait = rw; cfg_aw_wait = aww; cfg_w_wait = ww; cfg_b_wait = bw;
    cfg_rdata = rd; cfg_rresp = rr; cfg_bresp = br;
  endtask

  // One core request; model predicts latency/result, literals pin the model.
  task automatic txn(input logic rd, input logic wr, input logic [63:0] a, input logic [2:0] len,
                     input logic [7:0] mask, input logic [63:0] wd,
                     input int lit_lat, input logic lit_err, input logic [63:0] lit_rd);
    int lat, n, t0, mx;
    logic pre;
    pre = (rd && wr) || (len > 3) || ((a & ((64'd1 << len) - 64'd1)) != 64'd0);
    mx  = (cfg_aw_wait > cfg_w_wait) ? cfg_aw_wait : cfg_w_wait;
    if (pre)     lat = 1;
    else if (rd) lat = 4 + cfg_ar_wait + cfg_r_wait;
    else         lat = 3 + mx + cfg_b_wait;
    @(posedge clk); #1;
    exp_pre   = pre;
    exp_is_rd = rd;
    exp_err   = pre || (rd ? (cfg_rresp != 0) : (cfg_bresp != 0));
    exp_rd    = (!pre && rd) ? cfg_rdata : 64'h0;
    exp_addr  = a[31:0];
    exp_size  = len;
    exp_strb  = mask;
    exp_wdata = wd;
    n_ar = 0; n_r = 0; n_aw = 0; n_w = 0; n_b = 0; bus_seen = 0;
    MemRd = rd; MemWr = wr; addr = a; wr_len = len; wr_mask = mask; data_Wr = wd;
    t0 = cyc; exp_cyc = t0 + lat; done = 0; active = 1;
    n = 0;
    while (!done && n < 60) begin @(posedge clk); n++; end
    #1;
    MemRd = 0; MemWr = 0;
    if (!done) begin
      active = 0;
      chk("completion_timeout", 64'(done), 64'h1);
    end else begin
      chk("lat_literal", 64'(dv_cyc - t0), 64'(lit_lat));
      chk("err_literal", 64'(exp_err), 64'(lit_err));
      chk("rd_literal", last_rd, lit_rd);
      chk("bus_seen", 64'(bus_seen), 64'(!pre));
      chk("n_ar", 64'(n_ar), 64'(!pre && rd));
      chk("n_r", 64'(n_r), 64'(!pre && rd));
      chk("n_aw", 64'(n_aw), 64'(!pre && wr));
      chk("n_w", 64'(n_w), 64'(!pre && wr));
      chk("n_b", 64'(n_b), 64'(!pre && wr));
    end
  endtask

  initial begin
    int n;
    #3;
    chk("rst_data_valid", 64'(data_valid), 64'h0);
    chk("rst_data_error", 64'(data_error), 64'h0);
    chk("rst_data_Rd", data_Rd, 64'h0);
    chk("rst_valids", 64'({ar_valid, aw_valid, w_valid, r_ready, b_ready}), 64'h0);
    chk("rst_addr_strb", 64'({ar_addr, w_strb}), 64'h0);
    repeat (3) @(posedge clk);
    #1 rst = 0;

    slave_cfg(0, 0, 0, 0, 0, 64'h1122334455667788, 2'b00, 2'b00);
    txn(1, 0, 64'h80000008, 3'd3, 8'h00, 64'h0, 4, 1'b0, 64'h1122334455667788);

    slave_cfg(0, 0, 3, 0, 0, 64'h0, 2'b00, 2'b00);
    txn(0, 1, 64'h80000004, 3'd2, 8'hF0, 64'hDEADBEEF00000000, 6, 1'b0, 64'h0);

    txn(1, 0, 64'h80000003, 3'd1, 8'h00, 64'h0, 1, 1'b1, 64'h0);

    slave_cfg(0, 0, 0, 0, 0, 64'hCAFEF00D12345678, 2'b10, 2'b00);
    txn(1, 0, 64'h80000010, 3'd3, 8'h00, 64'h0, 4, 1'b1, 64'hCAFEF00D12345678);

    slave_cfg(2, 1, 0, 0, 0, 64'h0102030405060708, 2'b00, 2'b00);
    txn(1, 0, 64'h80000022, 3'd1, 8'h00, 64'h0, 7, 1'b0, 64'h0102030405060708);

    txn(1, 1, 64'h80000000, 3'd3, 8'hFF, 64'h55, 1, 1'b1, 64'h0);

    slave_cfg(0, 0, 0, 2, 1, 64'h0, 2'b00, 2'b11);
    txn(0, 1, 64'h80000040, 3'd3, 8'hFF, 64'hA5A5A5A55A5A5A5A, 6, 1'b1, 64'h0);

    txn(0, 1, 64'h80000004, 3'd3, 8'hFF, 64'h1, 1, 1'b1, 64'h0);
    txn(1, 0, 64'h80000000, 3'd4, 8'h00, 64'h0, 1, 1'b1, 64'h0);

    // Reset while waiting in the read-data phase
    slave_cfg(0, 5, 0, 0, 0, 64'hFFFF0000FFFF0000, 2'b00, 2'b00);
    @(posedge clk); #1;
    MemRd = 1; addr = 64'h80000100; wr_len = 3'd3;
    n = 0;
    while (!r_ready && n < 20) begin @(negedge clk); n++; end
    chk("rst_mid_reached_rdata", 64'(r_ready), 64'h1);
    #2 rst = 1;
    #1;
    chk("rst_mid_r_ready", 64'(r_ready), 64'h0);
    chk("rst_mid_dv", 64'({data_valid, ar_valid, aw_valid, w_valid, b_ready}), 64'h0);
    @(posedge clk); #1 MemRd = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;

    slave_cfg(0, 0, 0, 0, 0, 64'h0F0E0D0C0B0A0908, 2'b00, 2'b00);
    txn(1, 0, 64'h80000018, 3'd3, 8'h00, 64'h0, 4, 1'b0, 64'h0F0E0D0C0B0A0908);

    slave_cfg(0, 0, 0, 0, 0, 64'h0, 2'b00, 2'b00);
    txn(0, 1, 64'h80000007, 3'd0, 8'h80, 64'hAB00000000000000, 3, 1'b0, 64'h0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
